// File: rtl/line_setup.sv
// line_setup
// ----------
// Line-request setup stage in front of the Bresenham error datapath. It takes
// one pair of endpoints over a valid/ready handshake and rejects it if any
// coordinate is negative. Otherwise it normalises the line: a steep swap makes
// it shallow and a direction swap makes it run left to right. It then computes
// deltax/deltay/ystep and holds the parameter set stable until the downstream
// walker reports line_done.
//
// Ports
//   clk                        rising-edge clock
//   rst                        asynchronous, active-low reset
//   req_valid / req_ready      endpoint request handshake (ready only in IDLE)
//   x0_in, y0_in, x1_in, y1_in endpoint coordinates, legal range 0..4095
//   line_done                  downstream finished the line; releases params
//   params_valid               parameter outputs valid and stable
//   init_pulse                 one-cycle strobe: downstream loads error/y regs
//   steep                      x/y were swapped; downstream swaps back to plot
//   x_start, x_end, y_start    normalised endpoints (x_start <= x_end)
//   deltax, deltay             x_end-x_start and |y_end-y_start|
//   ystep                      +1 or -1 in WIDTH-bit two's complement
//   bad_coord                  one-cycle flag: request rejected
module line_setup #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] x0_in,
   input  logic [WIDTH-1:0] y0_in,
   input  logic [WIDTH-1:0] x1_in,
   input  logic [WIDTH-1:0] y1_in,
   input  logic             line_done,
   output logic             params_valid,
   output logic             init_pulse,
   output logic             steep,
   output logic [WIDTH-1:0] x_start,
   output logic [WIDTH-1:0] x_end,
   output logic [WIDTH-1:0] y_start,
   output logic [WIDTH-1:0] deltax,
   output logic [WIDTH-1:0] deltay,
   output logic [WIDTH-1:0] ystep,
   output logic             bad_coord
);

   typedef enum logic [2:0] {
      IDLE, CHECK, SWAP_STEEP, SWAP_DIR, DELTA, ISSUE, BUSY
   } state_t;

   localparam logic signed [WIDTH-1:0] STEP_POS = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic signed [WIDTH-1:0] STEP_NEG = {WIDTH{1'b1}};

   state_t state_q, state_d;

   // Working copy of the endpoints; swapped in place during normalisation.
   logic signed [WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;
   logic                    steep_q, pv_q, init_q, bad_q;
   logic signed [WIDTH-1:0] xs_q, xe_q, ys_q, dx_q, dy_q, ystep_q;

   logic coord_bad;
   logic is_steep;

   // Legal inputs are 0..4095, so a-b never overflows WIDTH signed bits.
   function automatic logic signed [WIDTH-1:0] abs_diff(
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b
   );
      logic signed [WIDTH-1:0] d;
      d = a - b;
      return d[WIDTH-1] ? -d : d;
   endfunction

   // A set sign bit is the only way a coordinate can leave 0..4095.
   assign coord_bad = x0_q[WIDTH-1] | y0_q[WIDTH-1] | x1_q[WIDTH-1] | y1_q[WIDTH-1];
   // Strictly greater: equal magnitudes stay non-steep.
   assign is_steep  = abs_diff(y1_q, y0_q) > abs_diff(x1_q, x0_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (req_valid) state_d = CHECK;
         CHECK:      state_d = coord_bad ? IDLE : SWAP_STEEP;
         SWAP_STEEP: state_d = SWAP_DIR;
         SWAP_DIR:   state_d = DELTA;
         DELTA:      state_d = ISSUE;
         ISSUE:      state_d = BUSY;
         BUSY:       if (line_done) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         steep_q <= 1'b0;
         pv_q    <= 1'b0;
         init_q  <= 1'b0;
         bad_q   <= 1'b0;
         xs_q    <= '0;
         xe_q    <= '0;
         ys_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         ystep_q <= STEP_POS;
      end else begin
         // Both strobes last a single cycle unless re-asserted below.
         init_q <= 1'b0;
         bad_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  x0_q <= x0_in;
                  y0_q <= y0_in;
                  x1_q <= x1_in;
                  y1_q <= y1_in;
               end
            end
            CHECK: begin
               if (coord_bad) bad_q   <= 1'b1;
               else           steep_q <= is_steep;
            end
            SWAP_STEEP: begin
               if (steep_q) begin
                  x0_q <= y0_q;
                  y0_q <= x0_q;
                  x1_q <= y1_q;
                  y1_q <= x1_q;
               end
            end
            SWAP_DIR: begin
               if (x0_q > x1_q) begin
                  x0_q <= x1_q;
                  y0_q <= y1_q;
                  x1_q <= x0_q;
                  y1_q <= y0_q;
               end
            end
            DELTA: begin
               xs_q    <= x0_q;
               xe_q    <= x1_q;
               ys_q    <= y0_q;
               dx_q    <= x1_q - x0_q;
               dy_q    <= abs_diff(y1_q, y0_q);
               // Horizontal lines get -1, which never matters since deltay=0.
               ystep_q <= (y0_q < y1_q) ? STEP_POS : STEP_NEG;
            end
            ISSUE: begin
               pv_q   <= 1'b1;
               init_q <= 1'b1;
            end
            BUSY: begin
               if (line_done) pv_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign params_valid = pv_q;
   assign init_pulse   = init_q;
   assign bad_coord    = bad_q;
   assign steep        = steep_q;
   assign x_start      = xs_q;
   assign x_end        = xe_q;
   assign y_start      = ys_q;
   assign deltax       = dx_q;
   assign deltay       = dy_q;
   assign ystep        = ystep_q;

endmodule

// File: tb/tb_line_setup.sv
module tb_line_setup;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [12:0] x0_in = '0, y0_in = '0, x1_in = '0, y1_in = '0;
   logic        line_done = 1'b0;
   logic        params_valid, init_pulse, steep, bad_coord;
   logic [12:0] x_start, x_end, y_start, deltax, deltay, ystep;

   int checks = 0;
   int passed = 0;

   line_setup #(.WIDTH(13)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
      .line_done(line_done),
      .params_valid(params_valid), .init_pulse(init_pulse), .steep(steep),
      .x_start(x_start), .x_end(x_end), .y_start(y_start),
      .deltax(deltax), .deltay(deltay), .ystep(ystep),
      .bad_coord(bad_coord)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      else passed++;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // ---------------- behavioural model ----------------
   // Accepted legal request: parameters become valid 5 edges after the
   // handshake edge; a rejected one flags bad_coord 1 edge after it.
   int m_idle = 1, m_cnt = 0, m_badreq = 0;
   int m_pv = 0, m_init = 0, m_bad = 0, m_fresh = 1;
   int c0, c1, c2, c3;
   int e_steep = 0, e_xs = 0, e_xe = 0, e_ys = 0, e_dx = 0, e_dy = 0, e_ystep = 1;

   task automatic compute_params();
      int ax, ay, bx, by, t, st;
      ax = c0; ay = c1; bx = c2; by = c3;
      st = (iabs(by - ay) > iabs(bx - ax)) ? 1 : 0;
      if (st != 0) begin
         t = ax; ax = ay; ay = t;
         t = bx; bx = by; by = t;
      end
      if (ax > bx) begin
         t = ax; ax = bx; bx = t;
         t = ay; ay = by; by = t;
      end
      e_steep = st;
      e_xs = ax; e_xe = bx; e_ys = ay;
      e_dx = bx - ax;
      e_dy = iabs(by - ay);
      e_ystep = (ay < by) ? 1 : 8191;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_idle = 1; m_cnt = 0; m_badreq = 0;
         m_pv = 0; m_init = 0; m_bad = 0; m_fresh = 1;
         e_steep = 0; e_xs = 0; e_xe = 0; e_ys = 0; e_dx = 0; e_dy = 0; e_ystep = 1;
      end else begin
         m_bad = 0;
         if (m_idle != 0) begin
            if (req_valid) begin
               c0 = int'(x0_in); c1 = int'(y0_in); c2 = int'(x1_in); c3 = int'(y1_in);
               m_idle = 0;
               m_badreq = (c0 > 4095 || c1 > 4095 || c2 > 4095 || c3 > 4095) ? 1 : 0;
               m_cnt = (m_badreq != 0) ? 1 : 5;
               if (m_badreq == 0) m_fresh = 0;
            end
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               if (m_badreq != 0) begin
                  m_bad = 1;
                  m_idle = 1;
               end else begin
                  compute_params();
                  m_pv = 1;
                  m_init = 1;
               end
            end
         end else begin
            m_init = 0;
            if (line_done) begin
               m_pv = 0;
               m_idle = 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("req_ready", 32'(req_ready), 32'(m_idle));
      chk("params_valid", 32'(params_valid), 32'(m_pv));
      chk("init_pulse", 32'(init_pulse), 32'(m_init));
      chk("bad_coord", 32'(bad_coord), 32'(m_bad));
      if (m_pv != 0 || m_fresh != 0) begin
         chk("steep", 32'(steep), 32'(e_steep));
         chk("x_start", 32'(x_start), 32'(e_xs));
         chk("x_end", 32'(x_end), 32'(e_xe));
         chk("y_start", 32'(y_start), 32'(e_ys));
         chk("deltax", 32'(deltax), 32'(e_dx));
         chk("deltay", 32'(deltay), 32'(e_dy));
         chk("ystep", 32'(ystep), 32'(e_ystep));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [12:0] a, input logic [12:0] b,
                       input logic [12:0] c, input logic [12:0] d);
      logic r;
      int ok;
      @(posedge clk); #2;
      x0_in = a; y0_in = b; x1_in = c; y1_in = d;
      req_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && ok == 0; i++) begin
         @(negedge clk);
         r = req_ready;
         @(posedge clk);
         if (r) ok = 1;
      end
      #2 req_valid = 1'b0;
      chk("handshake", 32'(ok), 32'd1);
   endtask

   task automatic wait_pv();
      int n;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         n++;
         if (params_valid) break;
      end
      chk("latency", 32'(n), 32'd5);
   endtask

   task automatic expect_lit(input logic s, input logic [12:0] xs, input logic [12:0] xe,
                             input logic [12:0] ys, input logic [12:0] dx,
                             input logic [12:0] dy, input logic [12:0] st);
      chk("lit_steep", 32'(steep), 32'(s));
      chk("lit_x_start", 32'(x_start), 32'(xs));
      chk("lit_x_end", 32'(x_end), 32'(xe));
      chk("lit_y_start", 32'(y_start), 32'(ys));
      chk("lit_deltax", 32'(deltax), 32'(dx));
      chk("lit_deltay", 32'(deltay), 32'(dy));
      chk("lit_ystep", 32'(ystep), 32'(st));
   endtask

   task automatic run_line(input logic [12:0] a, input logic [12:0] b,
                           input logic [12:0] c, input logic [12:0] d,
                           input logic s, input logic [12:0] xs, input logic [12:0] xe,
                           input logic [12:0] ys, input logic [12:0] dx,
                           input logic [12:0] dy, input logic [12:0] st);
      send(a, b, c, d);
      wait_pv();
      chk("lit_init_first", 32'(init_pulse), 32'd1);
      expect_lit(s, xs, xe, ys, dx, dy, st);
      @(posedge clk); #1;
      chk("lit_init_single", 32'(init_pulse), 32'd0);
      chk("lit_pv_held", 32'(params_valid), 32'd1);
      line_done = 1'b1;
      @(posedge clk); #2;
      line_done = 1'b0;
      chk("lit_pv_released", 32'(params_valid), 32'd0);
      chk("lit_ready_after_done", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_pv", 32'(params_valid), 32'd0);
      chk("rst_ystep", 32'(ystep), 32'd1);
      chk("rst_x_end", 32'(x_end), 32'd0);
      #1 rst = 1'b1;

      run_line(13'd0, 13'd0, 13'd10, 13'd4, 1'b0, 13'd0, 13'd10, 13'd0, 13'd10, 13'd4, 13'h0001);
      run_line(13'd10, 13'd4, 13'd0, 13'd0, 1'b0, 13'd0, 13'd10, 13'd0, 13'd10, 13'd4, 13'h0001);
      run_line(13'd2, 13'd1, 13'd5, 13'd9, 1'b1, 13'd1, 13'd9, 13'd2, 13'd8, 13'd3, 13'h0001);
      run_line(13'd0, 13'd8, 13'd6, 13'd2, 1'b0, 13'd0, 13'd6, 13'd8, 13'd6, 13'd6, 13'h1FFF);

      // Rejected request, then a degenerate legal one.
      send(13'h1000, 13'd0, 13'd5, 13'd5);
      @(posedge clk); #1;
      chk("bad_pulse", 32'(bad_coord), 32'd1);
      chk("bad_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      chk("bad_single", 32'(bad_coord), 32'd0);
      run_line(13'd3, 13'd3, 13'd3, 13'd3, 1'b0, 13'd3, 13'd3, 13'd3, 13'd0, 13'd0, 13'h1FFF);

      // req_valid held through BUSY, then reset mid-line.
      send(13'd1, 13'd1, 13'd4, 13'd2);
      req_valid = 1'b1;
      x0_in = 13'd7; y0_in = 13'd7; x1_in = 13'd9; y1_in = 13'd9;
      wait_pv();
      expect_lit(1'b0, 13'd1, 13'd4, 13'd1, 13'd3, 13'd1, 13'h0001);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("busy_no_accept", 32'(req_ready), 32'd0);
      end
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_pv", 32'(params_valid), 32'd0);
      chk("mid_rst_x_start", 32'(x_start), 32'd0);
      chk("mid_rst_deltax", 32'(deltax), 32'd0);
      chk("mid_rst_ystep", 32'(ystep), 32'd1);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(req_ready), 32'd1);
      chk("post_rst_pv", 32'(params_valid), 32'd0);

      run_line(13'd10, 13'd4, 13'd0, 13'd0, 1'b0, 13'd0, 13'd10, 13'd0, 13'd10, 13'd4, 13'h0001);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
